// File: rtl/alu_control_muldiv.sv
// rtl/alu_control_muldiv.sv - ALU op decoder with start/done sequencing for an iterative mul/div unit
//
// Decodes {funct7, ALU_Op, funct3} into an ALU operation code. Single-cycle ops
// pass straight through with no stall. M-extension ops launch the mul/div unit
// with a one-cycle start pulse, hold the pipeline while it runs, and flag the
// writeback mux for one cycle when the result is ready. A watchdog ends a
// stuck operation and sets a sticky error.
//
// Ports:
//   clk             core clock, rising edge
//   reset           asynchronous, active-high reset
//   valid_i         instruction fields are valid this cycle
//   funct7_i        instruction[31:25]
//   ALU_Op_i        instruction class from main control
//   funct3_i        instruction[14:12]
//   muldiv_done_i   one-cycle result-ready pulse from the mul/div unit
//   ALU_Operation_o operation code (zero-extended to OP_WIDTH)
//   muldiv_start_o  one-cycle start pulse to the mul/div unit
//   muldiv_sel_o    writeback selects the mul/div result
//   stall_o         hold PC and instruction register
//   illegal_o       unrecognised encoding while valid_i=1
//   error_o         sticky watchdog timeout flag
module alu_control_muldiv #(
    parameter int OP_WIDTH  = 4,
    parameter int TIMEOUT   = 64,
    parameter int CNT_WIDTH = $clog2(TIMEOUT) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    input  logic [6:0]          funct7_i,
    input  logic [2:0]          ALU_Op_i,
    input  logic [2:0]          funct3_i,
    input  logic                muldiv_done_i,
    output logic [OP_WIDTH-1:0] ALU_Operation_o,
    output logic                muldiv_start_o,
    output logic                muldiv_sel_o,
    output logic                stall_o,
    output logic                illegal_o,
    output logic                error_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [3:0]           op_q;
    logic [CNT_WIDTH-1:0] cnt;

    logic [3:0] dec_code;
    logic       dec_legal;
    logic       dec_multi;
    logic       launch;

    always_comb begin
        dec_code  = 4'b0000;
        dec_legal = 1'b0;
        dec_multi = 1'b0;
        case (ALU_Op_i)
            3'b000: begin
                case (funct7_i)
                    7'b0000000: begin
                        dec_legal = 1'b1;
                        case (funct3_i)
                            3'b000:  dec_code = 4'b0000;
                            3'b001:  dec_code = 4'b0011;
                            3'b100:  dec_code = 4'b0111;
                            3'b101:  dec_code = 4'b0100;
                            3'b110:  dec_code = 4'b0010;
                            3'b111:  dec_code = 4'b0110;
                            default: dec_legal = 1'b0;
                        endcase
                    end
                    7'b0100000: begin
                        dec_legal = 1'b1;
                        case (funct3_i)
                            3'b000:  dec_code = 4'b0101;
                            3'b101:  dec_code = 4'b1000;
                            default: dec_legal = 1'b0;
                        endcase
                    end
                    7'b0000001: begin
                        dec_legal = 1'b1;
                        dec_multi = 1'b1;
                        case (funct3_i)
                            3'b000: dec_code = 4'b1001;
                            3'b001: dec_code = 4'b1100;
                            3'b100: dec_code = 4'b1010;
                            3'b101: dec_code = 4'b1101;
                            3'b110: dec_code = 4'b1011;
                            3'b111: dec_code = 4'b1110;
                            default: begin
                                dec_legal = 1'b0;
                                dec_multi = 1'b0;
                            end
                        endcase
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            3'b001: begin
                dec_legal = 1'b1;
                case (funct3_i)
                    3'b000: dec_code = 4'b0000;
                    3'b100: dec_code = 4'b0111;
                    3'b110: dec_code = 4'b0010;
                    3'b111: dec_code = 4'b0110;
                    3'b001: begin
                        if (funct7_i == 7'b0000000) dec_code = 4'b0011;
                        else dec_legal = 1'b0;
                    end
                    3'b101: begin
                        if (funct7_i == 7'b0000000)      dec_code = 4'b0100;
                        else if (funct7_i == 7'b0100000) dec_code = 4'b1000;
                        else                             dec_legal = 1'b0;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            3'b010: begin
                dec_legal = 1'b1;
                dec_code  = 4'b0001;
            end
            3'b011: begin
                dec_legal = 1'b1;
                dec_code  = 4'b0000;
            end
            3'b100: begin
                dec_legal = 1'b1;
                dec_code  = 4'b0101;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // A new M op may only launch from IDLE; DONE deliberately blocks it so the
    // retiring instruction's writeback cycle is never overlapped.
    assign launch = (state == IDLE) && valid_i && dec_multi;

    assign muldiv_start_o  = launch;
    assign stall_o         = launch || (state == BUSY);
    assign muldiv_sel_o    = (state == DONE);
    assign illegal_o       = valid_i && !dec_legal;
    assign ALU_Operation_o = OP_WIDTH'((state == IDLE) ? dec_code : op_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= 4'b0000;
            cnt     <= '0;
            error_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        op_q  <= dec_code;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // done is tested first so it wins over a same-cycle timeout
                    if (muldiv_done_i) begin
                        state <= DONE;
                    end else if (cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
                        error_o <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_muldiv.sv
// tb/tb_alu_control_muldiv.sv - self-checking bench for alu_control_muldiv
module tb_alu_control_muldiv;

    localparam int TMO = 8;

    logic       clk;
    logic       reset;
    logic       valid;
    logic [6:0] f7;
    logic [2:0] aop;
    logic [2:0] f3;
    logic       done;
    logic [3:0] code;
    logic       start;
    logic       sel;
    logic       stall;
    logic       illegal;
    logic       err;

    int errors = 0;
    int checks = 0;
    bit err_model = 0;

    typedef struct {
        bit [2:0] op;
        bit [2:0] f3;
        bit [6:0] f7;
        bit       f7_any;
        bit       f3_any;
        bit [3:0] code;
        bit       multi;
    } rule_t;

    rule_t rules[$];

    alu_control_muldiv #(.OP_WIDTH(4), .TIMEOUT(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid),
        .funct7_i        (f7),
        .ALU_Op_i        (aop),
        .funct3_i        (f3),
        .muldiv_done_i   (done),
        .ALU_Operation_o (code),
        .muldiv_start_o  (start),
        .muldiv_sel_o    (sel),
        .stall_o         (stall),
        .illegal_o       (illegal),
        .error_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic add_rule(input bit [2:0] op, input bit [2:0] fn3, input bit [6:0] fn7,
                            input bit f7_any, input bit f3_any, input bit [3:0] c, input bit m);
        rule_t r;
        r.op = op; r.f3 = fn3; r.f7 = fn7; r.f7_any = f7_any; r.f3_any = f3_any;
        r.code = c; r.multi = m;
        rules.push_back(r);
    endtask

    // Mnemonic table: ADD SLL XOR SRL OR AND, SUB SRA, MUL-class, I-type, LUI, ADD, SUB.
    task automatic init_rules;
        add_rule(0, 0, 7'h00, 0, 0, 4'h0, 0); add_rule(0, 1, 7'h00, 0, 0, 4'h3, 0);
        add_rule(0, 4, 7'h00, 0, 0, 4'h7, 0); add_rule(0, 5, 7'h00, 0, 0, 4'h4, 0);
        add_rule(0, 6, 7'h00, 0, 0, 4'h2, 0); add_rule(0, 7, 7'h00, 0, 0, 4'h6, 0);
        add_rule(0, 0, 7'h20, 0, 0, 4'h5, 0); add_rule(0, 5, 7'h20, 0, 0, 4'h8, 0);
        add_rule(0, 0, 7'h01, 0, 0, 4'h9, 1); add_rule(0, 1, 7'h01, 0, 0, 4'hC, 1);
        add_rule(0, 4, 7'h01, 0, 0, 4'hA, 1); add_rule(0, 5, 7'h01, 0, 0, 4'hD, 1);
        add_rule(0, 6, 7'h01, 0, 0, 4'hB, 1); add_rule(0, 7, 7'h01, 0, 0, 4'hE, 1);
        add_rule(1, 0, 7'h00, 1, 0, 4'h0, 0); add_rule(1, 4, 7'h00, 1, 0, 4'h7, 0);
        add_rule(1, 6, 7'h00, 1, 0, 4'h2, 0); add_rule(1, 7, 7'h00, 1, 0, 4'h6, 0);
        add_rule(1, 1, 7'h00, 0, 0, 4'h3, 0); add_rule(1, 5, 7'h00, 0, 0, 4'h4, 0);
        add_rule(1, 5, 7'h20, 0, 0, 4'h8, 0);
        add_rule(2, 0, 7'h00, 1, 1, 4'h1, 0); add_rule(3, 0, 7'h00, 1, 1, 4'h0, 0);
        add_rule(4, 0, 7'h00, 1, 1, 4'h5, 0);
    endtask

    task automatic ref_lookup(input bit [6:0] fn7, input bit [2:0] op, input bit [2:0] fn3,
                              output bit [3:0] c, output bit legal, output bit m);
        c = 4'h0; legal = 0; m = 0;
        foreach (rules[i]) begin
            if (!legal && rules[i].op == op && (rules[i].f3_any || rules[i].f3 == fn3) &&
                (rules[i].f7_any || rules[i].f7 == fn7)) begin
                c = rules[i].code; legal = 1; m = rules[i].multi;
            end
        end
    endtask

    // Runs one M op from IDLE. lat = BUSY cycle carrying the done pulse; lat > TMO = never done.
    task automatic run_mop(input bit [6:0] fn7, input bit [2:0] op, input bit [2:0] fn3,
                           input bit [3:0] exp_code, input int lat, input string name);
        int  nbusy;
        bit  has_done;
        bit  e_stall, e_sel, e_start;
        has_done = (lat <= TMO);
        nbusy    = has_done ? lat : TMO;
        for (int c = 0; c <= nbusy + 2; c++) begin
            done = 1'b0;
            if (c == 0) begin
                valid = 1'b1; f7 = fn7; aop = op; f3 = fn3;
            end else if (c <= nbusy || (has_done && c == nbusy + 1)) begin
                valid = 1'($urandom); f7 = 7'($urandom); aop = 3'($urandom); f3 = 3'($urandom);
                if (c == nbusy && has_done) done = 1'b1;
            end else begin
                valid = 1'b0; f7 = 7'h00; aop = 3'd0; f3 = 3'd0;
            end
            #4;
            e_start = (c == 0);
            e_stall = (c <= nbusy);
            e_sel   = has_done && (c == nbusy + 1);
            checks++;
            if (start !== e_start) begin
                errors++; $display("FAIL %s start c=%0d got=%b exp=%b", name, c, start, e_start);
            end
            checks++;
            if (stall !== e_stall) begin
                errors++; $display("FAIL %s stall c=%0d got=%b exp=%b", name, c, stall, e_stall);
            end
            checks++;
            if (sel !== e_sel) begin
                errors++; $display("FAIL %s sel c=%0d got=%b exp=%b", name, c, sel, e_sel);
            end
            if (c <= nbusy || e_sel) begin
                checks++;
                if (code !== exp_code) begin
                    errors++; $display("FAIL %s code c=%0d got=%h exp=%h", name, c, code, exp_code);
                end
            end
            tick();
        end
        done = 1'b0;
        if (!has_done) err_model = 1;
        checks++;
        if (err !== err_model) begin
            errors++; $display("FAIL %s error_o got=%b exp=%b", name, err, err_model);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; valid = 0; f7 = 0; aop = 0; f3 = 0; done = 0;
        #2;
        checks++;
        if ({start, stall, sel, illegal, err} !== 5'b0 || code !== 4'h0) begin
            errors++; $display("FAIL reset_hold got=%b code=%h exp=00000 code=0", {start, stall, sel, illegal, err}, code);
        end
        tick(); tick();
        reset = 1'b0;
        #4;
        checks++;
        if ({start, stall, sel, illegal, err} !== 5'b0 || code !== 4'h0) begin
            errors++; $display("FAIL reset_release got=%b code=%h exp=00000 code=0", {start, stall, sel, illegal, err}, code);
        end
        tick();
    endtask

    task automatic test_decode;
        bit [6:0] t_f7[3] = '{7'h20, 7'h20, 7'h00};
        bit [2:0] t_op[3] = '{3'd0, 3'd1, 3'd2};
        bit [2:0] t_f3[3] = '{3'd0, 3'd5, 3'd3};
        bit [3:0] t_c[3]  = '{4'h5, 4'h8, 4'h1};
        for (int i = 0; i < 3; i++) begin
            valid = 1; f7 = t_f7[i]; aop = t_op[i]; f3 = t_f3[i];
            #4;
            checks++;
            if (code !== t_c[i]) begin
                errors++; $display("FAIL decode%0d code got=%h exp=%h", i, code, t_c[i]);
            end
            checks++;
            if (stall !== 1'b0 || start !== 1'b0 || illegal !== 1'b0) begin
                errors++; $display("FAIL decode%0d ctl got=%b%b%b exp=000", i, stall, start, illegal);
            end
            tick();
        end
        valid = 0;
    endtask

    task automatic test_mul;
        run_mop(7'h01, 3'd0, 3'd0, 4'h9, 3, "mul");
    endtask

    task automatic test_done_wins;
        run_mop(7'h01, 3'd0, 3'd5, 4'hD, TMO, "divu_done_at_limit");
    endtask

    task automatic test_random;
        bit [3:0] c;
        bit legal, m;
        for (int n = 0; n < 60; n++) begin
            case ($urandom % 4)
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            aop = 3'($urandom);
            f3 = 3'($urandom);
            if (aop == 3'd0 && f7 == 7'h01 && (f3 == 3'd2 || f3 == 3'd3)) f3 = 3'd0;
            valid = ($urandom % 5) != 0;
            ref_lookup(f7, aop, f3, c, legal, m);
            if (valid && m) begin
                run_mop(f7, aop, f3, c, 1 + int'($urandom % 5), "rand_mop");
            end else begin
                #4;
                checks++;
                if (code !== c) begin
                    errors++; $display("FAIL rand_code f7=%h op=%0d f3=%0d got=%h exp=%h", f7, aop, f3, code, c);
                end
                checks++;
                if (illegal !== (valid && !legal)) begin
                    errors++; $display("FAIL rand_illegal got=%b exp=%b", illegal, valid && !legal);
                end
                checks++;
                if ({start, stall, sel} !== 3'b000) begin
                    errors++; $display("FAIL rand_ctl got=%b exp=000", {start, stall, sel});
                end
                tick();
            end
        end
        valid = 0;
    endtask

    task automatic test_idle_done_illegal;
        valid = 0; done = 1; f7 = 0; aop = 0; f3 = 0;
        #4;
        checks++;
        if ({start, stall, sel} !== 3'b000) begin
            errors++; $display("FAIL idle_done got=%b exp=000", {start, stall, sel});
        end
        tick();
        done = 0; valid = 1; aop = 3'd7; f3 = 3'($urandom); f7 = 7'($urandom);
        #4;
        checks++;
        if (illegal !== 1'b1 || code !== 4'h0) begin
            errors++; $display("FAIL illegal_op7 got=%b code=%h exp=1 code=0", illegal, code);
        end
        checks++;
        if ({start, stall, sel} !== 3'b000) begin
            errors++; $display("FAIL illegal_ctl got=%b exp=000", {start, stall, sel});
        end
        tick();
        aop = 0; f7 = 0; f3 = 0;
        #4;
        checks++;
        if ({start, stall, sel, illegal} !== 4'b0000 || code !== 4'h0) begin
            errors++; $display("FAIL idle_after got=%b code=%h exp=0000 code=0", {start, stall, sel, illegal}, code);
        end
        tick();
        valid = 0;
    endtask

    task automatic test_timeout;
        run_mop(7'h01, 3'd0, 3'd4, 4'hA, 100, "div_timeout");
        valid = 1; f7 = 7'h00; aop = 3'd0; f3 = 3'd0;
        #4;
        checks++;
        if (code !== 4'h0 || {start, stall, sel, illegal} !== 4'b0000) begin
            errors++; $display("FAIL add_after_timeout got=%b code=%h exp=0000 code=0", {start, stall, sel, illegal}, code);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL error_sticky got=%b exp=1", err);
        end
        tick();
        valid = 0;
    endtask

    task automatic test_reset_midop;
        valid = 1; f7 = 7'h01; aop = 3'd0; f3 = 3'd4;
        #4;
        tick();
        valid = 0;
        #4;
        checks++;
        if (stall !== 1'b1 || code !== 4'hA) begin
            errors++; $display("FAIL midop_busy stall=%b code=%h exp=1 code=a", stall, code);
        end
        tick();
        #4;
        reset = 1;
        #1;
        err_model = 0;
        checks++;
        if ({start, stall, sel, err} !== 4'b0000) begin
            errors++; $display("FAIL midop_reset got=%b exp=0000", {start, stall, sel, err});
        end
        @(posedge clk);
        #1;
        reset = 0;
        run_mop(7'h01, 3'd0, 3'd6, 4'hB, 2, "rem_after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout reached");
        $fatal(1);
    end

    initial begin
        init_rules();
        test_reset();
        test_decode();
        test_mul();
        test_done_wins();
        test_random();
        test_idle_done_illegal();
        test_timeout();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_control_muldiv.md
Name: alu_control_muldiv

Overview:
Successor ALU decoder for the RISC-V core. It decodes full RV32I ALU R-type and I-type ops plus RV32M ops into a 4-bit-or-wider ALU operation code. For multi-cycle M-extension ops it runs a start/done handshake with an iterative mul/div unit, stalls the PC, and asserts a result-select strobe. A watchdog counter raises a sticky error if the unit never responds.

Parameters:
OP_WIDTH, 4, width of ALU_Operation_o; must be >= 4; codes are zero-extended.
TIMEOUT, 64, maximum BUSY cycles before the watchdog fires; must be >= 2.
CNT_WIDTH, $clog2(TIMEOUT)+1, watchdog counter width.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
valid_i  input  1  instruction fields below are valid this cycle
funct7_i  input  7  instruction[31:25]
ALU_Op_i  input  3  class from main control
funct3_i  input  3  instruction[14:12]
muldiv_done_i  input  1  one-cycle pulse from mul/div unit: result ready
ALU_Operation_o  output  OP_WIDTH  operation code to ALU / mul/div unit
muldiv_start_o  output  1  one-cycle start pulse to mul/div unit
muldiv_sel_o  output  1  writeback selects mul/div result
stall_o  output  1  hold PC and instruction register
illegal_o  output  1  unrecognised encoding while valid_i=1 (combinational)
error_o  output  1  sticky watchdog timeout flag

Behaviour:
- Decode, {funct7, ALU_Op, funct3} -> code:
  - ALU_Op 000, R-type:
    - f7=0000000: 000 ADD=0000, 001 SLL=0011, 100 XOR=0111, 101 SRL=0100, 110 OR=0010, 111 AND=0110.
    - f7=0100000: 000 SUB=0101, 101 SRA=1000.
    - f7=0000001 (multi-cycle): 000 MUL=1001, 001 MULH=1100, 100 DIV=1010, 101 DIVU=1101, 110 REM=1011, 111 REMU=1110.
  - ALU_Op 001, I-type (funct7 ignored except for shifts):
    - 000 ADDI=0000, 100 XORI=0111, 110 ORI=0010, 111 ANDI=0110.
    - 001 with f7=0000000 SLLI=0011.
    - 101 with f7=0000000 SRLI=0100; 101 with f7=0100000 SRAI=1000.
  - ALU_Op 010 LUI=0001. ALU_Op 011 (load/store/AUIPC) ADD=0000. ALU_Op 100 (branch) SUB=0101.
  - Anything else: code 0000; illegal_o=1 when valid_i=1. MUL-class encodings are not illegal.
- FSM states IDLE, BUSY, DONE. Reset -> IDLE, op_q=0, cnt=0, error_o=0.
- Combinational outputs muldiv_start_o, stall_o and muldiv_sel_o are 0 in IDLE with valid_i=0, so they read 0 during and after reset.
- IDLE:
  - ALU_Operation_o = live decode.
  - When valid_i=1 and the op is multi-cycle: muldiv_start_o=1 and stall_o=1 in the same cycle (combinational). On the clock edge, op_q <= code, cnt <= 0, state -> BUSY.
  - muldiv_done_i is ignored in IDLE.
- BUSY:
  - ALU_Operation_o = op_q; stall_o=1; start=0; inputs ignored.
  - On muldiv_done_i=1 -> DONE.
  - Otherwise cnt++. When cnt == TIMEOUT-1 with no done: error_o <= 1, state -> IDLE; that instruction retires with muldiv_sel_o=0.
  - done and timeout in the same cycle: done wins.
- DONE (exactly one cycle):
  - ALU_Operation_o = op_q; stall_o=0; muldiv_sel_o=1; no new start even if valid_i=1.
  - Next state IDLE.
- Latency: M op holds stall for 1 + N cycles, where N is the number of BUSY cycles up to and including the done pulse; the instruction retires in DONE.
- Single-cycle ops: zero latency, no stall, FSM stays IDLE.
- error_o clears only on reset.
- Reset mid-operation returns to IDLE immediately (asynchronous). All stall/start/sel outputs drop in that same cycle.

Test Plan:
- Reset, all inputs 0 -> all 1-bit outputs 0, ALU_Operation_o=0000, error_o=0.
- valid_i=1, R-type f7=0100000 f3=000 -> ALU_Operation_o=0101, stall_o=0; I-type f7=0100000 f3=101 -> 1000; ALU_Op=010 -> 0001.
- MUL (f7=0000001, Op=000, f3=000), done pulsed 3 cycles after start -> start=1 for 1 cycle, stall_o=1 for 4 cycles, then muldiv_sel_o=1 for 1 cycle with ALU_Operation_o=1001 throughout.
- DIV with done never asserted, TIMEOUT=8 -> stall_o=1 for 9 cycles, error_o=1 and stays set, FSM back in IDLE; a following ADD decodes normally.
- done pulsed while IDLE, and ALU_Op=111 with valid_i=1 -> no state change; illegal_o=1, code 0000.
- Reset asserted in BUSY mid-DIV -> stall_o and muldiv_sel_o drop immediately; after release, a new REM starts cleanly with code 1011.
